dvi_tmds_tx: RTL and testbench
==============================

Name: dvi_tmds_tx

Overview:
- Pixel-rate DVI 1.0 transmitter core with three TMDS channel encoders (8b/10b with DC balancing) plus a TMDS clock-channel word.
- Sits between the video timing/pixel pipeline (RGB, HS, VS, DE) and the external 10:1 serializers (OSER10 + ELVDS), which are outside this block.
- Runs entirely in the pixel clock domain.
- Outputs one 10-bit parallel word per channel per pixel clock.

Parameters:
- HS_POL, 1, sync polarity: encoder C0 = I_rgb_hs XOR ~HS_POL (1 = active-high passthrough).
- VS_POL, 1, same rule for C1 and I_rgb_vs.

Ports:
- I_rgb_clk  in  1  pixel clock; all logic on rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_rgb_vs  in  1  vertical sync.
- I_rgb_hs  in  1  horizontal sync.
- I_rgb_de  in  1  data enable; 1 = active pixel.
- I_rgb_r  in  8  red (channel 2).
- I_rgb_g  in  8  green (channel 1).
- I_rgb_b  in  8  blue (channel 0).
- O_tmds_ch0  out  10  encoded blue word; bit 0 is transmitted first.
- O_tmds_ch1  out  10  encoded green word.
- O_tmds_ch2  out  10  encoded red word.
- O_tmds_clk  out  10  clock-channel word.

Behaviour:
- Reset (async assert, sync release):
  - ch0, ch1, ch2 = 10'b1101010100.
  - All disparity counters = 0.
  - O_tmds_clk = 10'b0000011111 (constant; unaffected by reset).
- Latency: exactly 2 clocks from inputs to outputs, identical for all channels.
  - Stage 1 registers q_m[8:0], DE and C1/C0.
  - Stage 2 registers the output word and updates the counter.
- Control period (DE=0), output = token for {C1,C0}; counter forced to 0:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- Control bit mapping: ch0 C0=HS, C1=VS; ch1 and ch2 use C1=C0=0.
- Stage 1, q_m (N1(d) = popcount of the 8-bit input d):
  - XNOR path when N1(d)>4, or N1(d)==4 and d[0]==0.
  - q_m[0]=d[0]; q_m[i]=q_m[i-1] XNOR/XOR d[i].
  - q_m[8]=0 for XNOR, 1 for XOR.
- Stage 2, with n1/n0 = ones/zeros in q_m[7:0] and cnt = signed 5-bit running disparity:
  - If cnt==0 or n1==n0:
    - out={~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m8 ? (n1-n0) : (n0-n1).
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out={1, q_m8, ~q_m[7:0]}.
    - cnt += 2*q_m8 + (n0-n1).
  - Else:
    - out={0, q_m8, q_m[7:0]}.
    - cnt += -2*(~q_m8) + (n1-n0).
- Output word bit order is {q9..q0}; q0 is serialized first.
- DE changes take effect on a pixel boundary with no glitch word; the first active pixel after blanking starts from cnt=0.
- Reset mid-frame: outputs return to the control-00 token immediately (async).

Optional Feature:
- Macro DVI_TX_PATTERN_EN.
- When defined:
  - Adds input I_pattern (1 bit).
  - Adds an 11-bit active-pixel counter that clears while DE=0 and increments on each DE=1 clock.
  - When I_pattern=1, RGB is replaced before stage 1 by 8 vertical colour bars, 64 pixels each, selected by counter[8:6]: white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00), repeating.
  - Latency is unchanged.
- When undefined: no port, no counter; RGB passes straight through.

Test Plan:
- Assert I_rst_n=0 -> all channel words 1101010100, O_tmds_clk 0000011111.
- DE=0, HS=1, VS=0 -> 2 clocks later ch0=0010101011, ch1=ch2=1101010100. HS=1, VS=1 -> ch0=1010101011.
- After blanking, DE=1, B=0x00 for 3 clocks -> ch0 = 0100000000, 1111111111, 0100000000 (cnt -8, +2, -6).
- After blanking, DE=1, B=0xFF -> ch0=1000000000. R=0x10 -> ch2=0111110000 in the first active pixel.
- DE toggling every 4 clocks -> every first active word after blanking matches the cnt=0 encoding. Reference-model compare over 10k random pixels shows no mismatches and |cnt|<=8 at all times.
- With DVI_TX_PATTERN_EN, I_pattern=1, DE=1 for 512 clocks -> pixel 0 encodes 0xFF on all channels, pixel 64 encodes R=G=0xFF, B=0x00, and pixel 448 encodes all 0x00.

Source files
------------

// File: rtl/dvi_tmds_tx.sv
// dvi_tmds_tx: DVI TMDS 8b/10b pixel encoder; DVI_TX_PATTERN_EN adds a colour-bar generator with an I_pattern select.
module dvi_tmds_enc (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       de_i,
  input  logic [1:0] c_i,
  input  logic [7:0] d_i,
  output logic [9:0] q_o
);
  logic [8:0]        qm_d, qm_q;
  logic [1:0]        c_q;
  logic              de_q, xnor_sel;
  logic [3:0]        n1_d;
  logic [9:0]        q_d, q_q, tok;
  logic signed [4:0] cnt_d, cnt_q, diff;
  logic              cpos, cneg, dpos, dneg;
  always_comb begin
    n1_d = 4'($countones(d_i));
    xnor_sel = n1_d > 4'd4 || (n1_d == 4'd4 && !d_i[0]);
    qm_d = '0;
    qm_d[0] = d_i[0];
    for (int i = 1; i < 8; i++) qm_d[i] = qm_d[i-1] ^ d_i[i] ^ xnor_sel;
    qm_d[8] = !xnor_sel;
  end
  // n1 - n0 over q_m[7:0] is 2*n1 - 8
  assign diff = $signed({4'($countones(qm_q[7:0])), 1'b0} - 5'd8);
  assign tok  = c_q == 2'b00 ? 10'b1101010100 :
                c_q == 2'b01 ? 10'b0010101011 :
                c_q == 2'b10 ? 10'b0101010100 : 10'b1010101011;
  always_comb begin
    cpos = !cnt_q[4] && |cnt_q;
    cneg = cnt_q[4];
    dpos = !diff[4] && |diff;
    dneg = diff[4];
    q_d = {1'b0, qm_q[8], qm_q[7:0]};
    cnt_d = cnt_q - {3'b0, !qm_q[8], 1'b0} + diff;
    if (!de_q) begin
      q_d = tok;
      cnt_d = '0;
    end else if (!(|cnt_q) || !(|diff)) begin
      q_d = {!qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d = qm_q[8] ? cnt_q + diff : cnt_q - diff;
    end else if ((cpos && dpos) || (cneg && dneg)) begin
      q_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d = cnt_q + {3'b0, qm_q[8], 1'b0} - diff;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qm_q  <= '0;
      c_q   <= '0;
      de_q  <= 1'b0;
      q_q   <= 10'b1101010100;
      cnt_q <= '0;
    end else begin
      qm_q  <= qm_d;
      c_q   <= c_i;
      de_q  <= de_i;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end
  assign q_o = q_q;
endmodule

module dvi_tmds_tx #(
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic       I_rgb_clk,
  input  logic       I_rst_n,
  input  logic       I_rgb_vs,
  input  logic       I_rgb_hs,
  input  logic       I_rgb_de,
  input  logic [7:0] I_rgb_r,
  input  logic [7:0] I_rgb_g,
  input  logic [7:0] I_rgb_b,
`ifdef DVI_TX_PATTERN_EN
  input  logic       I_pattern,
`endif
  output logic [9:0] O_tmds_ch0,
  output logic [9:0] O_tmds_ch1,
  output logic [9:0] O_tmds_ch2,
  output logic [9:0] O_tmds_clk
);
  logic [7:0] r, g, b;
`ifdef DVI_TX_PATTERN_EN
  logic [10:0] px_q;
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) px_q <= '0;
    else px_q <= I_rgb_de ? px_q + 11'd1 : '0;
  end
  // bar index px_q[8:6]: bit2 kills green, bit1 kills red, bit0 kills blue
  assign r = I_pattern ? {8{!px_q[7]}} : I_rgb_r;
  assign g = I_pattern ? {8{!px_q[8]}} : I_rgb_g;
  assign b = I_pattern ? {8{!px_q[6]}} : I_rgb_b;
`else
  assign r = I_rgb_r;
  assign g = I_rgb_g;
  assign b = I_rgb_b;
`endif
  assign O_tmds_clk = 10'b0000011111;
  dvi_tmds_enc u_ch0 (.clk_i(I_rgb_clk), .rst_ni(I_rst_n), .de_i(I_rgb_de),
                      .c_i({I_rgb_vs ^ !VS_POL, I_rgb_hs ^ !HS_POL}), .d_i(b), .q_o(O_tmds_ch0));
  dvi_tmds_enc u_ch1 (.clk_i(I_rgb_clk), .rst_ni(I_rst_n), .de_i(I_rgb_de),
                      .c_i(2'b00), .d_i(g), .q_o(O_tmds_ch1));
  dvi_tmds_enc u_ch2 (.clk_i(I_rgb_clk), .rst_ni(I_rst_n), .de_i(I_rgb_de),
                      .c_i(2'b00), .d_i(r), .q_o(O_tmds_ch2));
endmodule

// File: tb/tb_dvi_tmds_tx.sv
// tb_dvi_tmds_tx: scoreboard bench for dvi_tmds_tx against an independent TMDS encoder model.
module tb_dvi_tmds_tx;
  logic clk = 0, rst_n = 0, vs = 0, hs = 0, de = 0, pat = 0;
  logic [7:0] r = 0, g = 0, b = 0;
  logic [9:0] ch0, ch1, ch2, tclk;
  int n_chk = 0, n_err = 0;
  int mcnt [3];
  logic [10:0] pxc = 0;
  logic drv = 0, v1 = 0, v2 = 0;
  logic [29:0] sb [$];
  localparam logic [9:0] T00 = 10'b1101010100;
  always #5 clk = ~clk;
  dvi_tmds_tx dut (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_rgb_vs(vs), .I_rgb_hs(hs), .I_rgb_de(de),
    .I_rgb_r(r), .I_rgb_g(g), .I_rgb_b(b),
`ifdef DVI_TX_PATTERN_EN
    .I_pattern(pat),
`endif
    .O_tmds_ch0(ch0), .O_tmds_ch1(ch1), .O_tmds_ch2(ch2), .O_tmds_clk(tclk)
  );
  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] enc(input int ch, input logic [7:0] d, input logic [1:0] c, input logic en);
    logic [8:0] qm;
    int n1d, n1, n0;
    logic xn;
    if (!en) begin
      mcnt[ch] = 0;
      case (c)
        2'b00: return 10'b1101010100;
        2'b01: return 10'b0010101011;
        2'b10: return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    n1d = $countones(d);
    xn = n1d > 4 || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (mcnt[ch] == 0 || n1 == n0) begin
      mcnt[ch] += qm[8] ? n1 - n0 : n0 - n1;
      return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    end
    if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
      mcnt[ch] += 2 * int'(qm[8]) + n0 - n1;
      return {1'b1, qm[8], ~qm[7:0]};
    end
    mcnt[ch] += -2 * int'(!qm[8]) + n1 - n0;
    return {1'b0, qm[8], qm[7:0]};
  endfunction
  task automatic step(input logic d, h, v, input logic [7:0] rr, gg, bb, input logic lit, input logic [29:0] lw);
    logic [7:0] er, eg, eb;
    logic [29:0] w;
    er = rr; eg = gg; eb = bb;
`ifdef DVI_TX_PATTERN_EN
    if (pat) begin
      er = {8{!pxc[7]}};
      eg = {8{!pxc[8]}};
      eb = {8{!pxc[6]}};
    end
    pxc = d ? pxc + 11'd1 : '0;
`endif
    de = d; hs = h; vs = v; r = rr; g = gg; b = bb; drv = 1;
    w = {enc(0, eb, {v, h}, d), enc(1, eg, 2'b00, d), enc(2, er, 2'b00, d)};
    sb.push_back(lit ? lw : w);
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    de = 0; hs = 0; vs = 0; drv = 0; pxc = '0;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    v1 <= drv;
    v2 <= v1;
  end
  always @(negedge clk) begin
    if (v2) begin
      if (sb.size() == 0) chk("sb_under", 10'(sb.size()), 10'd1);
      else begin
        logic [29:0] e;
        e = sb.pop_front();
        chk("ch0", ch0, e[29:20]);
        chk("ch1", ch1, e[19:10]);
        chk("ch2", ch2, e[9:0]);
      end
    end
  end
  initial begin
    logic d;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ch0", ch0, T00);
    chk("rst_ch1", ch1, T00);
    chk("rst_ch2", ch2, T00);
    chk("rst_clk", tclk, 10'b0000011111);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    step(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, {10'b0010101011, T00, T00});
    step(0, 1, 1, 8'h00, 8'h00, 8'h00, 1, {10'b1010101011, T00, T00});
    step(0, 0, 1, 8'h00, 8'h00, 8'h00, 0, '0);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, {T00, T00, T00});
    step(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, {3{10'b0100000000}});
    step(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, {3{10'b1111111111}});
    step(1, 0, 0, 8'h00, 8'h00, 8'h00, 1, {3{10'b0100000000}});
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, '0);
    step(1, 0, 0, 8'h10, 8'h10, 8'hFF, 1, {10'b1000000000, 10'b0111110000, 10'b0111110000});
    for (int k = 0; k < 64; k++)
      step(((k / 4) % 2) == 1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, '0);
    d = 1;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(7) == 0) d = !d;
      step(d, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, '0);
    end
    idle(3);
    de = 1;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_ch0", ch0, T00);
    chk("async_ch1", ch1, T00);
    chk("async_ch2", ch2, T00);
    @(negedge clk) rst_n = 1;
    idle(3);
`ifdef DVI_TX_PATTERN_EN
    pat = 1;
    for (int k = 0; k < 512; k++)
      step(1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), k == 0, {3{10'b1000000000}});
    idle(3);
    pat = 0;
`endif
    chk("sb_drain", 10'(sb.size()), 10'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
